// File: rtl/uart_tx_engine_param.sv
`timescale 1ns/1ps
// UART transmitter: write FIFO, per-frame config snapshot, 5..DATA_MAX_W data
// bits, optional parity, 1/1.5/2 stop bits, CTS gating and break override.
module uart_tx_engine_param #(
  parameter int DATA_MAX_W = 9,
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rstnn,
  input  logic                  baud_tick,
  input  logic                  wr_valid,
  input  logic [DATA_MAX_W-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  fifo_clear,
  output logic [CNT_W-1:0]      fifo_count,
  input  logic [3:0]            cfg_bits,
  input  logic [1:0]            cfg_stop,
  input  logic                  cfg_par_en,
  input  logic                  cfg_par_even,
  input  logic                  cfg_par_stick,
  input  logic                  cfg_break,
  input  logic                  cfg_cts_en,
  input  logic                  cts_n,
  output logic                  txd,
  output logic                  tx_busy,
  output logic                  tx_empty,
  output logic                  tx_done,
  output logic [2:0]            state
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(2 * OVERSAMPLE);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_START = 3'd2,
    S_DATA = 3'd3, S_PARITY = 3'd4, S_STOP = 3'd5
  } state_t;

  state_t st, st_nxt;

  logic [DATA_MAX_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  push, pop;

  logic [DATA_MAX_W-1:0] shifter, head_act;
  logic [3:0]            nb, nb_q, bit_idx;
  logic [1:0]            stop_q;
  logic                  par_en_q, par_bit, par_calc, frame_txd;
  logic [BW-1:0]         bit_cnt, stop_len;
  logic                  last;

  // A full FIFO refuses pushes based on the registered count, so a pop in the
  // same cycle cannot make room for a push.
  assign wr_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign push     = wr_valid && wr_ready;
  assign pop      = baud_tick && (st == S_LOAD) && (fifo_count != '0);

  // FIFO pointers and occupancy; clear overrides push and pop
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (fifo_clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (push && !fifo_clear) mem[wr_ptr] <= wr_data;
  end

  // Clamp the requested data width into 5..DATA_MAX_W
  always_comb begin
    nb = cfg_bits;
    if (cfg_bits < 4'd5)                      nb = 4'd5;
    else if (cfg_bits > 4'(DATA_MAX_W))       nb = 4'(DATA_MAX_W);
  end

  // Mask FIFO head to active bits and derive the parity bit for LOAD
  always_comb begin
    head_act = '0;
    for (int i = 0; i < DATA_MAX_W; i++) head_act[i] = mem[rd_ptr][i] && (i < int'(nb));
    if (cfg_par_stick) par_calc = ~cfg_par_even;
    else               par_calc = cfg_par_even ? ^head_act : ~^head_act;
  end

  // Stop period length minus one, from the snapshotted stop setting
  always_comb begin
    case (stop_q)
      2'b00:   stop_len = BW'(OVERSAMPLE - 1);
      2'b01:   stop_len = BW'(3 * OVERSAMPLE / 2 - 1);
      default: stop_len = BW'(2 * OVERSAMPLE - 1);
    endcase
  end

  assign last = (bit_cnt == '0);

  // Next-state logic
  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE:   if (fifo_count != '0 && !(cfg_cts_en && cts_n)) st_nxt = S_LOAD;
      S_LOAD:   st_nxt = S_START;
      S_START:  if (last) st_nxt = S_DATA;
      S_DATA:   if (last && bit_idx == nb_q - 4'd1) st_nxt = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (last) st_nxt = S_STOP;
      S_STOP:   if (last) st_nxt = S_IDLE;
      default:  st_nxt = S_IDLE;
    endcase
  end

  // State register and frame datapath, advanced only on baud ticks
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      st       <= S_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
      nb_q     <= '0;
      stop_q   <= '0;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
    end else if (baud_tick) begin
      st <= st_nxt;
      case (st)
        S_LOAD: begin
          shifter  <= head_act;
          nb_q     <= nb;
          stop_q   <= cfg_stop;
          par_en_q <= cfg_par_en;
          par_bit  <= par_calc;
          bit_cnt  <= BW'(OVERSAMPLE - 1);
        end
        S_START: begin
          bit_idx <= '0;
          bit_cnt <= last ? BW'(OVERSAMPLE - 1) : bit_cnt - 1'b1;
        end
        S_DATA: begin
          if (last) begin
            bit_cnt <= (st_nxt == S_STOP) ? stop_len : BW'(OVERSAMPLE - 1);
            shifter <= shifter >> 1;
            bit_idx <= bit_idx + 4'd1;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        S_PARITY: bit_cnt <= last ? stop_len : bit_cnt - 1'b1;
        S_STOP:   if (!last) bit_cnt <= bit_cnt - 1'b1;
        default:  bit_cnt <= '0;
      endcase
    end
  end

  // One-clk pulse after the final stop tick
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) tx_done <= 1'b0;
    else        tx_done <= baud_tick && (st == S_STOP) && last;
  end

  // Line level implied by the current frame phase
  always_comb begin
    case (st)
      S_START:  frame_txd = 1'b0;
      S_DATA:   frame_txd = shifter[0];
      S_PARITY: frame_txd = par_bit;
      default:  frame_txd = 1'b1;
    endcase
  end

  assign txd      = cfg_break ? 1'b0 : frame_txd;
  assign state    = st;
  assign tx_busy  = (st != S_IDLE);
  assign tx_empty = (fifo_count == '0) && (st == S_IDLE);
endmodule

// File: tb/tb_uart_tx_engine_param.sv
`timescale 1ns/1ps
// Bench for uart_tx_engine_param: table of frame configurations checked
// clock-by-clock against a bench-built line waveform, plus FIFO, CTS,
// reset and break sequences.
module tb_uart_tx_engine_param;
  localparam int DW = 9, FD = 16, OS = 16, CW = $clog2(FD) + 1;

  logic          clk = 1'b0, rstnn = 1'b0, baud_tick = 1'b0;
  logic          wr_valid = 1'b0, fifo_clear = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [3:0]    cfg_bits = 4'd8;
  logic [1:0]    cfg_stop = 2'b00;
  logic          cfg_par_en = 0, cfg_par_even = 0, cfg_par_stick = 0;
  logic          cfg_break = 0, cfg_cts_en = 0, cts_n = 0;
  logic          wr_ready, txd, tx_busy, tx_empty, tx_done;
  logic [CW-1:0] fifo_count;
  logic [2:0]    state;

  uart_tx_engine_param #(.DATA_MAX_W(DW), .FIFO_DEPTH(FD), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rstnn(rstnn), .baud_tick(baud_tick), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready), .fifo_clear(fifo_clear),
    .fifo_count(fifo_count), .cfg_bits(cfg_bits), .cfg_stop(cfg_stop),
    .cfg_par_en(cfg_par_en), .cfg_par_even(cfg_par_even),
    .cfg_par_stick(cfg_par_stick), .cfg_break(cfg_break),
    .cfg_cts_en(cfg_cts_en), .cts_n(cts_n), .txd(txd), .tx_busy(tx_busy),
    .tx_empty(tx_empty), .tx_done(tx_done), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] bits;
    logic [1:0] stop;
    logic       pen, peven, pstick;
    logic [8:0] data;
    int         nb;      // expected active data bits
    logic       pbit;    // expected parity bit
    int         stop_t;  // expected stop ticks
  } vec_t;

  vec_t tbl[8];
  vec_t sb[$];
  int   checks = 0, failures = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_cfg(input vec_t v);
    cfg_bits = v.bits; cfg_stop = v.stop; cfg_par_en = v.pen;
    cfg_par_even = v.peven; cfg_par_stick = v.pstick;
  endtask

  // Called at a negedge; push lands on the following posedge
  task automatic push_word(input logic [8:0] d);
    wr_data = d; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic send(input vec_t v);
    set_cfg(v);
    sb.push_back(v);
    push_word(v.data);
  endtask

  // Pops the next expected frame, waits for LOAD and compares txd every clk.
  // Config (and cts_n) is scrambled mid-frame to prove the snapshot holds.
  task automatic check_frame(input bit push_in_load, input logic [8:0] pdata);
    vec_t v, v2;
    bit   w[$];
    int   waitc, bad;
    if (sb.size() == 0) begin check("sb_empty", 0, 1); return; end
    v = sb.pop_front();
    w.push_back(1'b1);
    repeat (OS) w.push_back(1'b0);
    for (int i = 0; i < v.nb; i++) repeat (OS) w.push_back(v.data[i]);
    if (v.pen) repeat (OS) w.push_back(v.pbit);
    repeat (v.stop_t) w.push_back(1'b1);
    waitc = 0;
    while (state != 3'd1 && waitc < 300) begin @(negedge clk); waitc++; end
    check({v.name, "_lat"}, waitc, 1);
    if (waitc >= 300) return;
    bad = -1;
    for (int k = 0; k < w.size(); k++) begin
      if (txd !== w[k] && bad < 0) bad = k;
      if (tx_done && bad < 0) bad = 1000 + k;
      if (k == 0 && push_in_load) begin
        v2 = v; v2.name = {v.name, "_b"}; v2.data = pdata;
        sb.push_back(v2);
        wr_data = pdata; wr_valid = 1'b1;
      end
      if (k == 1 && push_in_load) begin
        wr_valid = 1'b0;
        check({v.name, "_pushpop_cnt"}, fifo_count, 1);
      end
      if (k == 40) begin
        cfg_bits = (v.bits == 4'd5) ? 4'd9 : 4'd5;
        cfg_stop = ~v.stop; cfg_par_en = ~v.pen;
        cfg_par_even = ~v.peven; cfg_par_stick = ~v.pstick;
        cts_n = 1'b1;
      end
      @(negedge clk);
    end
    set_cfg(v);
    cts_n = 1'b0;
    check({v.name, "_wave"}, bad, -1);
    check({v.name, "_done"}, tx_done, 1);
    check({v.name, "_idle"}, state, 0);
    check({v.name, "_empty"}, tx_empty, (sb.size() == 0) ? 1 : 0);
  endtask

  initial begin
    int n;
    tbl[0] = '{"8N1_A5",   4'd8,  2'b00, 0, 0, 0, 9'h0A5, 8, 0, 16};
    tbl[1] = '{"7E2_35",   4'd7,  2'b10, 1, 1, 0, 9'h035, 7, 0, 32};
    tbl[2] = '{"7S1_35",   4'd7,  2'b10, 1, 0, 1, 9'h035, 7, 1, 32};
    tbl[3] = '{"9N15_1FF", 4'd9,  2'b01, 0, 0, 0, 9'h1FF, 9, 0, 24};
    tbl[4] = '{"b3_1FF",   4'd3,  2'b00, 0, 0, 0, 9'h1FF, 5, 0, 16};
    tbl[5] = '{"8O2_00",   4'd8,  2'b11, 1, 0, 0, 9'h000, 8, 1, 32};
    tbl[6] = '{"b15_155",  4'd15, 2'b00, 0, 0, 0, 9'h155, 9, 0, 16};
    tbl[7] = '{"6S0_2A",   4'd6,  2'b00, 1, 1, 1, 9'h02A, 6, 0, 16};

    // Reset values
    baud_tick = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_state", state, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", wr_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_empty", tx_empty, 1);
    check("rst_done", tx_done, 0);
    rstnn = 1'b1;
    @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      send(tbl[i]);
      check_frame(1'b0, 9'h0);
    end

    // Back-to-back, with a push coinciding with the LOAD pop
    send(tbl[0]);
    check_frame(1'b1, 9'h0C3);
    check_frame(1'b0, 9'h0);

    // FIFO fill with ticks stopped
    baud_tick = 1'b0;
    for (int i = 0; i < 16; i++) push_word(9'(i + 1));
    check("full_ready", wr_ready, 0);
    check("full_count", fifo_count, 16);
    push_word(9'h0AA);
    check("drop_count", fifo_count, 16);
    check("notick_state", state, 0);
    fifo_clear = 1'b1; wr_data = 9'h055; wr_valid = 1'b1;
    @(negedge clk);
    fifo_clear = 1'b0; wr_valid = 1'b0;
    check("clear_count", fifo_count, 0);
    check("clear_ready", wr_ready, 1);
    baud_tick = 1'b1;
    repeat (3) @(negedge clk);
    check("clear_idle", state, 0);

    // CTS gating
    cfg_cts_en = 1'b1; cts_n = 1'b1;
    sb.push_back(tbl[0]); set_cfg(tbl[0]); push_word(9'h0A5);
    repeat (20) @(negedge clk);
    check("cts_hold_state", state, 0);
    check("cts_hold_txd", txd, 1);
    check("cts_hold_count", fifo_count, 1);
    cts_n = 1'b0;
    check_frame(1'b0, 9'h0);
    cfg_cts_en = 1'b0;

    // Async reset mid-DATA
    set_cfg(tbl[0]);
    push_word(9'h000);
    push_word(9'h000);
    n = 0;
    while (state != 3'd1 && n < 300) begin @(negedge clk); n++; end
    repeat (40) @(negedge clk);
    check("pre_rst_state", state, 3);
    check("pre_rst_txd", txd, 0);
    #1 rstnn = 1'b0;
    #1;
    check("mid_rst_txd", txd, 1);
    check("mid_rst_state", state, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_empty", tx_empty, 1);
    @(negedge clk);
    rstnn = 1'b1;
    @(negedge clk);

    // Break forces the line low while the frame runs on
    cfg_break = 1'b1;
    @(negedge clk);
    check("brk_idle_txd", txd, 0);
    push_word(9'h1FF);
    n = 0;
    while (state != 3'd1 && n < 300) begin @(negedge clk); n++; end
    repeat (150) @(negedge clk);
    check("brk_stop_state", state, 5);
    check("brk_stop_txd", txd, 0);
    n = 0;
    while (!tx_done && n < 40) begin @(negedge clk); n++; end
    check("brk_done", tx_done, 1);
    cfg_break = 1'b0;
    @(negedge clk);
    check("brk_release_txd", txd, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_engine_param.md
Name: uart_tx_engine_param

Overview:
Parametrised successor to the 16550-style UART transmitter. Contains a write FIFO of configurable depth, a frame engine for 5..DATA_MAX_W data bits, and selectable 1/1.5/2 stop bits. Adds CTS flow control, per-frame configuration snapshot, and a frame-done pulse. Sits between the UART register block, which supplies config and writes, and the TXD pad, driven by the shared baud-rate tick generator.

Parameters:
DATA_MAX_W, 9, maximum data bits per frame (5..9); also the FIFO word width.
FIFO_DEPTH, 16, FIFO entries; power of 2, at least 2.
OVERSAMPLE, 16, baud_tick pulses per bit; even, at least 4.
CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count (derived).

Ports:
clk  in  1  system clock
rstnn  in  1  asynchronous active-low reset
baud_tick  in  1  one-clk enable pulse at OVERSAMPLE x baud rate
wr_valid  in  1  push request
wr_data  in  DATA_MAX_W  push data
wr_ready  out  1  FIFO not full
fifo_clear  in  1  synchronous FIFO flush
fifo_count  out  CNT_W  FIFO occupancy
cfg_bits  in  4  data bits per frame
cfg_stop  in  2  stop bits: 00=1, 01=1.5, 10/11=2
cfg_par_en  in  1  parity enable
cfg_par_even  in  1  even parity select
cfg_par_stick  in  1  stick parity
cfg_break  in  1  force TXD low
cfg_cts_en  in  1  CTS gating enable
cts_n  in  1  clear-to-send, active low
txd  out  1  serial output
tx_busy  out  1  frame in progress (state != IDLE)
tx_empty  out  1  FIFO empty and state == IDLE
tx_done  out  1  one-clk pulse at the end of each stop period
state  out  3  IDLE=0, LOAD=1, START=2, DATA=3, PARITY=4, STOP=5

Behaviour:
- Reset (async, rstnn=0): state IDLE, txd 1, fifo_count 0, FIFO pointers 0, wr_ready 1, tx_busy 0, tx_empty 1, tx_done 0, all counters 0.
- Reset mid-frame takes effect immediately. The frame is lost and txd returns to 1 without waiting for a clock.
- FIFO push: occurs when wr_valid && wr_ready. wr_ready = (fifo_count < FIFO_DEPTH), taken from the registered count. A push while full is dropped, even if a pop happens in the same cycle.
- Push and pop in the same cycle leave the count unchanged.
- fifo_clear zeroes the count and pointers and wins over a coincident push or pop. A frame already in LOAD or later completes normally.
- All state advances happen only on baud_tick=1. With baud_tick=0, every register except the FIFO holds.
- IDLE -> LOAD on a tick when fifo_count != 0 and !(cfg_cts_en && cts_n). Otherwise remain in IDLE with txd=1.
- LOAD (one tick):
  - pops the FIFO head into the shifter;
  - snapshots cfg_bits, cfg_stop, cfg_par_*;
  - computes parity over the active bits;
  - goes to START.
  - Later config changes do not affect the current frame.
- cfg_bits < 5 acts as 5; cfg_bits > DATA_MAX_W acts as DATA_MAX_W. Bits above the active count are ignored.
- START: txd=0 for OVERSAMPLE ticks, then DATA.
- DATA: LSB first, each bit held OVERSAMPLE ticks. After the last active bit, go to PARITY if parity is enabled, otherwise STOP.
- PARITY bit:
  - stick=0, even=0: odd parity (~^data);
  - stick=0, even=1: even parity (^data);
  - stick=1, even=0: 1;
  - stick=1, even=1: 0.
- STOP: txd=1 for OVERSAMPLE, 3*OVERSAMPLE/2, or 2*OVERSAMPLE ticks. On the final tick, tx_done pulses for one clk and state goes to IDLE.
- Back-to-back frames: STOP -> IDLE -> LOAD on consecutive ticks when the FIFO is non-empty.
- CTS is sampled only in IDLE. Deasserting CTS mid-frame does not abort the frame.
- txd = cfg_break ? 0 : frame_txd, combinational. The state machine keeps running during break, so frames sent during break are lost on the line.
- Bit-time counter: counts down from OVERSAMPLE-1 (or the stop length minus 1) to 0 and reloads on each bit boundary. There is no wrap beyond the loaded value.

Test Plan:
- 8N1 with OVERSAMPLE=16, baud_tick every clk, push 0xA5:
  - txd shows 0,1,0,1,0,0,1,0,1,1, each bit 16 clks;
  - tx_done pulses 161 clks after LOAD begins;
  - tx_empty returns to 1.
- 7E2, push 0x35:
  - data bits 1,0,1,0,1,1,0, then parity 0, then stop high for 32 ticks;
  - with stick=1, even=0, the parity bit is 1.
- 9-bit, no parity, 1.5 stop, push 0x1FF: nine 1-bits, then stop for 24 ticks. With cfg_bits=3, the frame has 5 data bits.
- FIFO full, baud_tick=0, 17 pushes:
  - wr_ready falls after the 16th push;
  - the 17th push is dropped and fifo_count=16;
  - fifo_clear together with wr_valid gives count 0.
- CTS: with cfg_cts_en=1, cts_n=1, and 1 entry queued, state stays IDLE and txd=1. After cts_n=0 the frame starts. Setting cts_n=1 mid-DATA does not change the frame.
- Assert rstnn=0 mid-DATA: txd=1 and state=0 with no clk edge; fifo_count=0. Separately, cfg_break=1 forces txd=0 at any state.
